// File: rtl/seg7_ctrl.sv
// seg7_ctrl: register file, round-robin write arbiter and clock
// dividers feeding the 8-digit seven-segment scanner.
module seg7_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_we,
  input  logic                  bus_re,
  input  logic [1:0]            bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic                  bus_ack,
  output logic [31:0]           bus_rdata,
  input  logic                  dbg_req,
  input  logic [DIGITS*4-1:0]   dbg_data,
  output logic                  dbg_ack,
  output logic                  scan_clk,
  output logic                  blink,
  output logic [DIGITS*4-1:0]   data,
  output logic [DIGITS-1:0]     point,
  output logic [DIGITS-1:0]     en
);

  localparam int DW = DIGITS * 4;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [0:0]        r_state;
  logic              r_ptr;
  logic              r_bus_ack;
  logic              r_dbg_ack;
  logic [DW-1:0]     r_data;
  logic [DIGITS-1:0] r_point;
  logic [DIGITS-1:0] r_en;
  logic [1:0]        r_ctrl;
  logic [31:0]       r_rdata;
  logic [SW-1:0]     r_scnt;
  logic              r_scan;
  logic [BW-1:0]     r_bcnt;
  logic              r_blink;

  logic              w_idle;
  logic              w_both;
  logic              w_gnt_bus;
  logic              w_gnt_dbg;
  logic [DW-1:0]     w_data_n;
  logic [DIGITS-1:0] w_point_n;
  logic [DIGITS-1:0] w_en_n;
  logic [1:0]        w_ctrl_n;
  logic [31:0]       w_rd;
  logic              w_unused;

  assign w_unused = ^bus_wdata;

  // r_ptr low selects the bus when both sides request together
  assign w_idle    = (r_state == S_IDLE);
  assign w_both    = bus_we & dbg_req;
  assign w_gnt_bus = w_idle & bus_we & (~dbg_req | ~r_ptr);
  assign w_gnt_dbg = w_idle & dbg_req & (~bus_we | r_ptr);

  always_comb begin
    w_data_n  = r_data;
    w_point_n = r_point;
    w_en_n    = r_en;
    w_ctrl_n  = r_ctrl;
    if (w_gnt_bus) begin
      unique case (bus_addr)
        2'd0: if (!r_ctrl[1]) w_data_n = bus_wdata[DW-1:0];
        2'd1: w_point_n = bus_wdata[DIGITS-1:0];
        2'd2: w_en_n    = bus_wdata[DIGITS-1:0];
        2'd3: w_ctrl_n  = bus_wdata[1:0];
      endcase
    end
    if (w_gnt_dbg) w_data_n = dbg_data;
  end

  // reads see the value committed on the same edge
  always_comb begin
    w_rd = '0;
    unique case (bus_addr)
      2'd0: w_rd[DW-1:0]     = w_data_n;
      2'd1: w_rd[DIGITS-1:0] = w_point_n;
      2'd2: w_rd[DIGITS-1:0] = w_en_n;
      2'd3: w_rd[1:0]        = w_ctrl_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_bus_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_data    <= '0;
      r_point   <= '0;
      r_en      <= '1;
      r_ctrl    <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= (w_gnt_bus | w_gnt_dbg) ? S_ACK : S_IDLE;
      if (w_idle && w_both) r_ptr <= ~r_ptr;
      r_bus_ack <= w_gnt_bus;
      r_dbg_ack <= w_gnt_dbg;
      r_data    <= w_data_n;
      r_point   <= w_point_n;
      r_en      <= w_en_n;
      r_ctrl    <= w_ctrl_n;
      if (bus_re) r_rdata <= w_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0;
      r_scan <= 1'b0;
    end else if (r_scnt == SMAX) begin
      r_scnt <= '0;
      r_scan <= ~r_scan;
    end else begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !r_ctrl[0]) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_bcnt == BMAX) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign bus_ack   = r_bus_ack;
  assign dbg_ack   = r_dbg_ack;
  assign bus_rdata = r_rdata;
  assign scan_clk  = r_scan;
  assign blink     = r_blink;
  assign data      = r_data;
  assign point     = r_point;
  assign en        = r_en;

endmodule

// File: tb/tb_seg7_ctrl.sv
// tb_seg7_ctrl: directed and random checks of seg7_ctrl against
// an arithmetic reference model of registers, arbiter and dividers.
module tb_seg7_ctrl;

  localparam int SDIV = 4;
  localparam int BDIV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = '0;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_data = '0;
  logic        dbg_ack;
  logic        scan_clk;
  logic        blink;
  logic [31:0] data;
  logic [7:0]  point;
  logic [7:0]  en;

  seg7_ctrl #(
    .DIGITS(8),
    .SCAN_DIV(SDIV),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dbg_req(dbg_req), .dbg_data(dbg_data),
    .dbg_ack(dbg_ack), .scan_clk(scan_clk),
    .blink(blink), .data(data),
    .point(point), .en(en)
  );

  always #5 clk = ~clk;

  logic [31:0] m_data = '0;
  logic [31:0] m_rdata = '0;
  logic [7:0]  m_point = '0;
  logic [7:0]  m_en = 8'hFF;
  logic [1:0]  m_ctrl = '0;
  bit          m_ptr_dbg = 0;
  bit          m_busy = 0;
  bit          m_back = 0;
  bit          m_dack = 0;
  int          m_k = 0;
  int          m_bn = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return 32'(m_point);
      2'd2:    return 32'(m_en);
      default: return 32'(m_ctrl);
    endcase
  endfunction

  // model one rising edge from the inputs currently applied
  task automatic model_edge();
    bit gb, gd;
    if (rst) begin
      m_data = '0; m_point = '0; m_en = 8'hFF; m_ctrl = '0;
      m_rdata = '0; m_ptr_dbg = 0; m_busy = 0;
      m_back = 0; m_dack = 0; m_k = 0; m_bn = 0;
      return;
    end
    m_k++;
    m_bn = m_ctrl[0] ? m_bn + 1 : 0;
    gb = 0; gd = 0;
    if (!m_busy) begin
      if (bus_we && dbg_req) begin
        if (m_ptr_dbg) gd = 1; else gb = 1;
        m_ptr_dbg = !m_ptr_dbg;
      end else begin
        gb = bus_we;
        gd = dbg_req;
      end
    end
    if (gb) begin
      case (bus_addr)
        2'd0: if (!m_ctrl[1]) m_data = bus_wdata;
        2'd1: m_point = bus_wdata[7:0];
        2'd2: m_en = bus_wdata[7:0];
        default: m_ctrl = bus_wdata[1:0];
      endcase
    end
    if (gd) m_data = dbg_data;
    m_busy = gb || gd;
    m_back = gb;
    m_dack = gd;
    if (bus_re) m_rdata = m_reg(bus_addr);
  endtask

  task automatic check_all();
    chk("data", data, m_data);
    chk("point", 32'(point), 32'(m_point));
    chk("en", 32'(en), 32'(m_en));
    chk("rdata", bus_rdata, m_rdata);
    chk("bus_ack", 32'(bus_ack), 32'(m_back));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_dack));
    chk("scan_clk", 32'(scan_clk), 32'((m_k / SDIV) % 2));
    chk("blink", 32'(blink), 32'((m_bn / BDIV) % 2));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    bus_re = 1'b0;
    if (rst) begin
      bus_we  = 1'b0;
      dbg_req = 1'b0;
    end else begin
      if (bus_ack) bus_we = 1'b0;
      if (dbg_ack) dbg_req = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    for (int t = 0; t < 8 && bus_we; t++) tick();
    chk("bus_wr_timeout", 32'(bus_we), 32'd0);
    tick();
  endtask

  initial begin
    int first;
    int tog;
    logic prev;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_en", 32'(en), 32'hFF);
    chk("rst_data", data, 32'h0);
    chk("rst_scan", 32'(scan_clk), 32'd0);

    first = -1; tog = 0; prev = scan_clk;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (scan_clk !== prev) begin
        tog++;
        if (first < 0) first = i;
      end
      prev = scan_clk;
    end
    chk("scan_first", 32'(first), 32'd4);
    chk("scan_toggles", 32'(tog), 32'd16);

    bus_addr = 2'd0; bus_wdata = 32'h1234ABCD; bus_we = 1'b1;
    tick();
    chk("wr_ack_pulse", 32'(bus_ack), 32'd1);
    tick();
    chk("wr_ack_once", 32'(bus_ack), 32'd0);
    chk("wr_data", data, 32'h1234ABCD);
    bus_re = 1'b1; bus_addr = 2'd0;
    tick();
    chk("rd_data", bus_rdata, 32'h1234ABCD);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_addr = 2'd0; bus_wdata = 32'h11111111; bus_we = 1'b1;
    dbg_data = 32'h22222222; dbg_req = 1'b1;
    tick();
    chk("pair1_bus_first", 32'({bus_ack, dbg_ack}), 32'b10);
    tick();
    tick();
    chk("pair1_dbg_later", 32'({bus_ack, dbg_ack}), 32'b01);
    tick();
    chk("pair1_data", data, 32'h22222222);
    bus_wdata = 32'h33333333; bus_we = 1'b1;
    dbg_data = 32'h44444444; dbg_req = 1'b1;
    tick();
    chk("pair2_dbg_first", 32'({bus_ack, dbg_ack}), 32'b01);
    tick();
    tick();
    chk("pair2_bus_later", 32'({bus_ack, dbg_ack}), 32'b10);
    tick();
    chk("pair2_data", data, 32'h33333333);

    bus_write(2'd3, 32'h2);
    bus_addr = 2'd0; bus_wdata = 32'hFFFFFFFF; bus_we = 1'b1;
    tick();
    chk("lock_ack", 32'(bus_ack), 32'd1);
    tick();
    chk("lock_data", data, 32'h33333333);
    dbg_data = 32'h5A5A5A5A; dbg_req = 1'b1;
    tick();
    chk("lock_dbg_ack", 32'(dbg_ack), 32'd1);
    tick();
    chk("lock_dbg_data", data, 32'h5A5A5A5A);
    bus_write(2'd3, 32'h0);

    bus_write(2'd3, 32'h1);
    tog = 0; prev = blink;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (blink !== prev) tog++;
      prev = blink;
    end
    chk("blink_toggles", 32'(tog), 32'd4);
    bus_write(2'd3, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("blink_off", 32'(blink), 32'd0);

    bus_addr = 2'd0; bus_wdata = 32'h77777777; bus_we = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ack", 32'(bus_ack), 32'd0);
    chk("rst_mid_data", data, 32'h0);
    bus_wdata = 32'h88888888; bus_we = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_req_ack", 32'(bus_ack), 32'd0);
    chk("rst_req_data", data, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if (!bus_we && $urandom_range(3) == 0) begin
        bus_addr  = 2'($urandom_range(3));
        bus_wdata = $urandom;
        bus_we    = 1'b1;
      end
      if (!dbg_req && $urandom_range(3) == 0) begin
        dbg_data = $urandom;
        dbg_req  = 1'b1;
      end
      if ($urandom_range(2) == 0) begin
        bus_re = 1'b1;
        if (!bus_we) bus_addr = 2'($urandom_range(3));
      end
      rst = ($urandom_range(99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
